// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared constants and types for the three-channel SDRAM arbiter
package sdram_pkg;
    localparam int CH_PRG     = 0;
    localparam int CH_CHR     = 1;
    localparam int CH_MCU     = 2;
    localparam int NUM_CH     = 3;
    localparam int AW_DEFAULT = 22;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_t;
endpackage

// File: rtl/sdram_prio_enc.sv
// rtl/sdram_prio_enc.sv - fixed-priority encoder, lowest pending channel wins
module sdram_prio_enc
    import sdram_pkg::*;
(
    input  logic [2:0] pending,
    output logic       valid,
    output logic [1:0] index
);
    assign valid = |pending;

    always_comb begin
        index = 2'(CH_PRG);
        if (pending[CH_PRG])
            index = 2'(CH_PRG);
        else if (pending[CH_CHR])
            index = 2'(CH_CHR);
        else if (pending[CH_MCU])
            index = 2'(CH_MCU);
    end
endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - toggle-handshake arbiter sharing one SDRAM controller between three channels with refresh
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int REFRESH_HOLD = 8,
    parameter int AW           = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ch0_req,
    output logic          ch0_ack,
    input  logic          ch0_we,
    input  logic [AW-1:0] ch0_address,
    input  logic [15:0]   ch0_data_write,
    output logic [15:0]   ch0_data_read,
    input  logic          ch1_req,
    output logic          ch1_ack,
    input  logic          ch1_we,
    input  logic [AW-1:0] ch1_address,
    input  logic [15:0]   ch1_data_write,
    output logic [15:0]   ch1_data_read,
    input  logic          ch2_req,
    output logic          ch2_ack,
    input  logic          ch2_we,
    input  logic [AW-1:0] ch2_address,
    input  logic [15:0]   ch2_data_write,
    output logic [15:0]   ch2_data_read,
    input  logic          refresh,
    output logic          ram_req,
    input  logic          ram_ack,
    output logic          ram_we,
    output logic [AW-1:0] ram_address,
    output logic [15:0]   ram_data_write,
    input  logic [15:0]   ram_data_read,
    output logic          ram_refresh
);
    localparam int HW = $clog2(REFRESH_HOLD + 1);

    state_t        state;
    logic          refresh_pending;
    logic [HW-1:0] hold_cnt;
    logic [1:0]    gnt_idx;
    logic [2:0]    req_vec;
    logic [2:0]    ack_q;
    logic [2:0]    pending;
    logic          grant_valid;
    logic [1:0]    grant_index;
    logic [15:0]   data_read_q [NUM_CH];
    logic          sel_we;
    logic [AW-1:0] sel_address;
    logic [15:0]   sel_data;
    logic          refresh_go;
    logic          done;

    assign req_vec = {ch2_req, ch1_req, ch0_req};
    assign pending = req_vec ^ ack_q;

    assign ch0_ack       = ack_q[CH_PRG];
    assign ch1_ack       = ack_q[CH_CHR];
    assign ch2_ack       = ack_q[CH_MCU];
    assign ch0_data_read = data_read_q[CH_PRG];
    assign ch1_data_read = data_read_q[CH_CHR];
    assign ch2_data_read = data_read_q[CH_MCU];

    sdram_prio_enc u_prio (
        .pending (pending),
        .valid   (grant_valid),
        .index   (grant_index)
    );

    always_comb begin
        sel_we      = ch0_we;
        sel_address = ch0_address;
        sel_data    = ch0_data_write;
        case (grant_index)
            2'(CH_CHR): begin
                sel_we      = ch1_we;
                sel_address = ch1_address;
                sel_data    = ch1_data_write;
            end
            2'(CH_MCU): begin
                sel_we      = ch2_we;
                sel_address = ch2_address;
                sel_data    = ch2_data_write;
            end
            default: ;
        endcase
    end

    // A pulse arriving on the very cycle we sit in IDLE is honoured immediately so refresh always beats a grant.
    assign refresh_go = (state == ST_IDLE) && (refresh_pending || refresh);
    assign done       = (state == ST_BUSY) && (ram_ack == ram_req);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            refresh_pending <= 1'b0;
            hold_cnt        <= '0;
            gnt_idx         <= '0;
            ack_q           <= '0;
            ram_req         <= 1'b0;
            ram_refresh     <= 1'b0;
            ram_we          <= 1'b0;
            ram_address     <= '0;
            ram_data_write  <= '0;
            for (int i = 0; i < NUM_CH; i++)
                data_read_q[i] <= '0;
        end else begin
            ram_refresh <= 1'b0;
            if (refresh_go)
                refresh_pending <= 1'b0;
            else if (refresh)
                refresh_pending <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (refresh_go) begin
                        ram_refresh <= 1'b1;
                        hold_cnt    <= HW'(REFRESH_HOLD - 1);
                        state       <= (REFRESH_HOLD > 1) ? ST_HOLD : ST_IDLE;
                    end else if (grant_valid) begin
                        ram_we         <= sel_we;
                        ram_address    <= sel_address;
                        ram_data_write <= sel_data;
                        ram_req        <= ~ram_req;
                        gnt_idx        <= grant_index;
                        state          <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (done) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (gnt_idx == 2'(i)) begin
                                if (!ram_we)
                                    data_read_q[i] <= ram_data_read;
                                ack_q[i] <= ~ack_q[i];
                            end
                        end
                        state <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt <= HW'(1)) begin
                        hold_cnt <= '0;
                        state    <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - self-checking bench with a behavioural SDRAM controller and command scoreboard
module tb_sdram_arbiter;
    localparam int AW           = 22;
    localparam int REFRESH_HOLD = 8;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    req = 3'b000;
    logic [2:0]    we = 3'b000;
    logic [AW-1:0] addr [3];
    logic [15:0]   wd [3];
    logic          refresh = 1'b0;
    logic          ram_ack = 1'b0;
    logic [15:0]   ram_data_read = 16'h0000;

    logic          ch0_ack, ch1_ack, ch2_ack;
    logic [15:0]   ch0_data_read, ch1_data_read, ch2_data_read;
    logic          ram_req, ram_we, ram_refresh;
    logic [AW-1:0] ram_address;
    logic [15:0]   ram_data_write;
    logic [2:0]    ack_vec;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   ctl_delay = 3;
    int   ctl_cnt = 0;
    logic ctl_busy = 1'b0;
    int   last_grant_cyc = -1;
    int   grant_cnt = 0;
    int   ref_cnt = 0;
    int   last_ref_cyc = -1;

    cmd_t        exp_q [$];
    logic [15:0] rd_q [$];

    assign ack_vec = {ch2_ack, ch1_ack, ch0_ack};

    sdram_arbiter #(.REFRESH_HOLD(REFRESH_HOLD), .AW(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ch0_req        (req[0]),
        .ch0_ack        (ch0_ack),
        .ch0_we         (we[0]),
        .ch0_address    (addr[0]),
        .ch0_data_write (wd[0]),
        .ch0_data_read  (ch0_data_read),
        .ch1_req        (req[1]),
        .ch1_ack        (ch1_ack),
        .ch1_we         (we[1]),
        .ch1_address    (addr[1]),
        .ch1_data_write (wd[1]),
        .ch1_data_read  (ch1_data_read),
        .ch2_req        (req[2]),
        .ch2_ack        (ch2_ack),
        .ch2_we         (we[2]),
        .ch2_address    (addr[2]),
        .ch2_data_write (wd[2]),
        .ch2_data_read  (ch2_data_read),
        .refresh        (refresh),
        .ram_req        (ram_req),
        .ram_ack        (ram_ack),
        .ram_we         (ram_we),
        .ram_address    (ram_address),
        .ram_data_write (ram_data_write),
        .ram_data_read  (ram_data_read),
        .ram_refresh    (ram_refresh)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Controller model and grant scoreboard, evaluated on the falling edge.
    initial begin
        cmd_t e;
        forever begin
            @(negedge clk);
            if (ram_refresh) begin
                ref_cnt++;
                last_ref_cyc = cyc;
            end
            if (!rst_n) begin
                ram_ack  = 1'b0;
                ctl_busy = 1'b0;
            end else if (ctl_busy) begin
                ctl_cnt--;
                if (ctl_cnt <= 0) begin
                    if (!ram_we)
                        ram_data_read = (rd_q.size() > 0) ? rd_q.pop_front() : 16'hDEAD;
                    else
                        ram_data_read = 16'hBAD0;
                    ram_ack  = ~ram_ack;
                    ctl_busy = 1'b0;
                end
            end else if (ram_req != ram_ack) begin
                ctl_busy       = 1'b1;
                ctl_cnt        = ctl_delay;
                last_grant_cyc = cyc;
                grant_cnt++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL grant_cmd: unexpected grant we=%0b addr=%h data=%h, none expected",
                             ram_we, ram_address, ram_data_write);
                end else begin
                    e = exp_q.pop_front();
                    if ({ram_we, ram_address, ram_data_write} !== {e.we, e.addr, e.data}) begin
                        bad++;
                        $display("FAIL grant_cmd: got we=%0b addr=%h data=%h expected we=%0b addr=%h data=%h",
                                 ram_we, ram_address, ram_data_write, e.we, e.addr, e.data);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int ch, input logic w, input logic [AW-1:0] a, input logic [15:0] d);
        cmd_t c;
        we[ch]   = w;
        addr[ch] = a;
        wd[ch]   = d;
        req[ch]  = ~req[ch];
        c.we   = w;
        c.addr = a;
        c.data = d;
        exp_q.push_back(c);
    endtask

    task automatic wait_ack(input int ch, output int at);
        logic start;
        start = ack_vec[ch];
        at = -1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (ack_vec[ch] != start) begin
                at = cyc;
                break;
            end
        end
        total++;
        if (at < 0) begin
            bad++;
            $display("FAIL ack_timeout: ch%0d ack stayed %0b, required a toggle", ch, start);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        total++;
        if ({ram_req, ram_refresh, ram_we, ram_address, ram_data_write, ack_vec,
             ch0_data_read, ch1_data_read, ch2_data_read} !== '0) begin
            bad++;
            $display("FAIL reset_state: req=%0b refr=%0b we=%0b addr=%h wd=%h ack=%b rd=%h/%h/%h, required all zero",
                     ram_req, ram_refresh, ram_we, ram_address, ram_data_write, ack_vec,
                     ch0_data_read, ch1_data_read, ch2_data_read);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write();
        int k, at;
        ctl_delay = 3;
        k = cyc;
        issue(1, 1'b1, 22'h00123, 16'hBEEF);
        tick();
        addr[1] = 22'h2AAAAA;
        wd[1]   = 16'h5555;
        we[1]   = 1'b0;
        wait_ack(1, at);
        total++;
        if (last_grant_cyc - k !== 1) begin
            bad++;
            $display("FAIL write_grant_latency: %0d cycles, required 1", last_grant_cyc - k);
        end
        total++;
        if (at - k !== 5) begin
            bad++;
            $display("FAIL write_ack_latency: %0d cycles, required 5", at - k);
        end
        total++;
        if (ch1_data_read !== 16'h0000) begin
            bad++;
            $display("FAIL write_no_read_latch: ch1_data_read=%h, required 0000", ch1_data_read);
        end
    endtask

    task automatic test_priority();
        int a0, a2;
        ctl_delay = 2;
        rd_q.push_back(16'h1234);
        rd_q.push_back(16'h5678);
        issue(0, 1'b0, 22'h000010, 16'h0000);
        issue(2, 1'b0, 22'h000020, 16'h0000);
        wait_ack(0, a0);
        total++;
        if (ch0_data_read !== 16'h1234) begin
            bad++;
            $display("FAIL prio_ch0_data: %h, required 1234", ch0_data_read);
        end
        total++;
        if (ch2_ack !== 1'b0) begin
            bad++;
            $display("FAIL prio_ch2_early: ch2_ack=%0b, required 0", ch2_ack);
        end
        wait_ack(2, a2);
        total++;
        if (last_grant_cyc !== a0 + 1) begin
            bad++;
            $display("FAIL prio_ch2_grant: cycle %0d, required %0d", last_grant_cyc, a0 + 1);
        end
        total++;
        if ({ch0_data_read, ch2_data_read} !== {16'h1234, 16'h5678}) begin
            bad++;
            $display("FAIL prio_data: ch0=%h ch2=%h, required 1234 5678", ch0_data_read, ch2_data_read);
        end
    endtask

    task automatic test_refresh();
        int k, at, r0;
        ctl_delay = 2;
        r0 = ref_cnt;
        rd_q.push_back(16'h4321);
        k = cyc;
        issue(0, 1'b0, 22'h3FFFFF, 16'h0000);
        refresh = 1'b1;
        tick();
        refresh = 1'b0;
        total++;
        if (ram_refresh !== 1'b1) begin
            bad++;
            $display("FAIL refresh_pulse_high: ram_refresh=%0b, required 1", ram_refresh);
        end
        tick();
        total++;
        if (ram_refresh !== 1'b0) begin
            bad++;
            $display("FAIL refresh_pulse_width: ram_refresh=%0b, required 0", ram_refresh);
        end
        wait_ack(0, at);
        total++;
        if (last_grant_cyc !== k + 1 + REFRESH_HOLD) begin
            bad++;
            $display("FAIL refresh_hold_grant: grant cycle %0d, required %0d", last_grant_cyc, k + 1 + REFRESH_HOLD);
        end
        total++;
        if (ref_cnt - r0 !== 1 || ch0_data_read !== 16'h4321) begin
            bad++;
            $display("FAIL refresh_count_data: pulses=%0d data=%h, required 1 4321", ref_cnt - r0, ch0_data_read);
        end
    endtask

    task automatic test_refresh_merge();
        int a, r0;
        ctl_delay = 6;
        r0 = ref_cnt;
        issue(2, 1'b1, 22'h000ABC, 16'hC0DE);
        tick();
        refresh = 1'b1;
        tick();
        refresh = 1'b0;
        tick();
        refresh = 1'b1;
        tick();
        refresh = 1'b0;
        wait_ack(2, a);
        repeat (REFRESH_HOLD + 4) tick();
        total++;
        if (ref_cnt - r0 !== 1) begin
            bad++;
            $display("FAIL refresh_merge_count: %0d pulses, required 1", ref_cnt - r0);
        end
        total++;
        if (last_ref_cyc !== a + 1) begin
            bad++;
            $display("FAIL refresh_merge_time: cycle %0d, required %0d", last_ref_cyc, a + 1);
        end
    endtask

    task automatic test_refresh_at_ack();
        int r0, ready, c;
        logic start;
        ctl_delay = 2;
        r0 = ref_cnt;
        start = ch1_ack;
        rd_q.push_back(16'h0A0A);
        issue(1, 1'b0, 22'h000777, 16'h0000);
        tick();
        ready = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (ram_ack == ram_req) begin
                ready = 1;
                break;
            end
        end
        refresh = 1'b1;
        tick();
        refresh = 1'b0;
        c = cyc;
        total++;
        if (ready == 0 || ch1_ack === start || ch1_data_read !== 16'h0A0A) begin
            bad++;
            $display("FAIL ack_with_refresh: ready=%0d ack=%0b data=%h, required toggled ack and 0A0A",
                     ready, ch1_ack, ch1_data_read);
        end
        repeat (REFRESH_HOLD + 2) tick();
        total++;
        if (ref_cnt - r0 !== 1 || last_ref_cyc !== c + 1) begin
            bad++;
            $display("FAIL refresh_with_ack: pulses=%0d at %0d, required 1 at %0d", ref_cnt - r0, last_ref_cyc, c + 1);
        end
    endtask

    task automatic test_back_to_back();
        int a1, a2;
        ctl_delay = 1;
        rd_q.push_back(16'h1111);
        rd_q.push_back(16'h2222);
        issue(1, 1'b0, 22'h000100, 16'h0000);
        wait_ack(1, a1);
        total++;
        if (ch1_data_read !== 16'h1111) begin
            bad++;
            $display("FAIL b2b_first_data: %h, required 1111", ch1_data_read);
        end
        issue(1, 1'b0, 22'h000101, 16'h0000);
        wait_ack(1, a2);
        total++;
        if (last_grant_cyc !== a1 + 1 || ch1_data_read !== 16'h2222) begin
            bad++;
            $display("FAIL b2b_second: grant %0d data %h, required %0d 2222", last_grant_cyc, ch1_data_read, a1 + 1);
        end
    endtask

    task automatic test_cancel();
        int g0, a;
        logic start1;
        ctl_delay = 5;
        g0 = grant_cnt;
        start1 = ch1_ack;
        rd_q.push_back(16'h7777);
        issue(0, 1'b0, 22'h3FFFFE, 16'h0000);
        tick();
        tick();
        req[1] = ~req[1];
        tick();
        req[1] = ~req[1];
        wait_ack(0, a);
        repeat (6) tick();
        total++;
        if (grant_cnt - g0 !== 1 || ch1_ack !== start1) begin
            bad++;
            $display("FAIL cancel: grants=%0d ch1_ack=%0b, required 1 grant and ch1_ack %0b", grant_cnt - g0, ch1_ack, start1);
        end
        total++;
        if (ch0_data_read !== 16'h7777) begin
            bad++;
            $display("FAIL cancel_ch0_data: %h, required 7777", ch0_data_read);
        end
    endtask

    task automatic test_reset_busy();
        int g0;
        ctl_delay = 6;
        issue(0, 1'b0, 22'h155555, 16'h0000);
        tick();
        tick();
        rst_n = 1'b0;
        req = 3'b000;
        tick();
        total++;
        if ({ram_req, ram_refresh, ram_we, ram_address, ram_data_write, ack_vec,
             ch0_data_read, ch1_data_read, ch2_data_read} !== '0) begin
            bad++;
            $display("FAIL reset_busy_state: req=%0b refr=%0b we=%0b addr=%h wd=%h ack=%b rd=%h/%h/%h, required all zero",
                     ram_req, ram_refresh, ram_we, ram_address, ram_data_write, ack_vec,
                     ch0_data_read, ch1_data_read, ch2_data_read);
        end
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        rd_q.delete();
        g0 = grant_cnt;
        repeat (10) tick();
        total++;
        if (ack_vec !== 3'b000 || ram_req !== 1'b0 || grant_cnt !== g0) begin
            bad++;
            $display("FAIL reset_busy_quiet: ack=%b ram_req=%0b grants=%0d, required 000 0 0",
                     ack_vec, ram_req, grant_cnt - g0);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            addr[i] = '0;
            wd[i]   = '0;
        end
        test_reset();
        test_write();
        test_priority();
        test_refresh();
        test_refresh_merge();
        test_refresh_at_ack();
        test_back_to_back();
        test_cancel();
        test_reset_busy();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d commands never granted, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter REFRESH_HOLD, default 8, meaning the number of clk cycles that grants are blocked after a refresh is issued.
REQ-002 SHALL have parameter AW, default 22, meaning the SDRAM word address width.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 chN_req  input  1  request toggle per channel, N=0 PRG, 1 CHR, 2 MCU.
REQ-006 chN_ack  output  1  acknowledge toggle per channel.
REQ-007 chN_we  input  1  write enable per channel.
REQ-008 chN_address  input  AW  word address per channel.
REQ-009 chN_data_write  input  16  write data per channel.
REQ-010 chN_data_read  output  16  read data per channel, held until that channel's next completion.
REQ-011 refresh  input  1  one-cycle refresh request pulse.
REQ-012 ram_req  output  1  toggle request to the SDRAM controller.
REQ-013 ram_ack  input  1  toggle completion from the SDRAM controller.
REQ-014 ram_we, ram_address[AW], ram_data_write[16]  output  forwarded command fields.
REQ-015 ram_data_read  input  16  controller read data, valid when ram_ack equals ram_req.
REQ-016 ram_refresh  output  1  one-cycle auto-refresh command pulse.

Function
REQ-017 A channel SHALL be pending while chN_req != chN_ack.
REQ-018 The FSM SHALL have three states: IDLE, BUSY and HOLD.
REQ-019 In IDLE with refresh_pending set, the FSM SHALL pulse ram_refresh for one cycle, clear refresh_pending, load the hold counter with REFRESH_HOLD-1 and enter HOLD.
- Refresh beats any pending channel.
REQ-020 In IDLE with no refresh pending and at least one channel pending, the FSM SHALL grant the lowest pending N (fixed priority 0>1>2).
- On grant: copy that channel's we/address/data_write to the ram_* outputs, toggle ram_req, record the grant index, enter BUSY.
- Grant-to-ram_req latency: 1 cycle.
REQ-021 In BUSY, when ram_ack == ram_req the FSM SHALL, on that edge:
- latch ram_data_read into the granted channel's chN_data_read (reads only; writes leave it unchanged);
- toggle that chN_ack;
- return to IDLE.
REQ-022 A new grant SHALL be possible the cycle after return to IDLE; back-to-back requests from one channel SHALL each be served.
REQ-023 In HOLD, the counter SHALL decrement each cycle and the FSM SHALL return to IDLE when it reaches 0; no grants occur in HOLD.
REQ-024 A refresh pulse in any state SHALL set refresh_pending; pulses arriving while it is already set SHALL merge into one.
REQ-025 Simultaneous refresh pulse and ram_ack completion SHALL both take effect: the ack toggles and refresh_pending is set.
REQ-026 Command fields SHALL be captured at grant; requester changes to we/address/data during BUSY SHALL have no effect.
REQ-027 A channel that re-toggles chN_req before its ack SHALL be treated as not pending if the toggles cancel before grant; after grant the in-flight access SHALL complete and ack normally.
REQ-028 A lower-priority channel SHALL wait while higher ones are pending (starvation accepted; channel 0 is rate-limited by the bus).

Reset
REQ-029 On rst_n low at a clk edge, all of the following SHALL be cleared: state=IDLE, ram_req=0, chN_ack=0, ram_refresh=0, refresh_pending=0, hold counter=0, ram_we=0, ram_address=0, ram_data_write=0, chN_data_read=0.
REQ-030 Reset mid-BUSY SHALL abandon the access with no ack; the controller is reset in the same cycle.

Structure
REQ-031 Channel index constants (CH_PRG=0, CH_CHR=1, CH_MCU=2), the FSM state enum and the default AW SHALL live in the shared sdram_pkg package.
REQ-032 The priority grant SHALL be a sub-module, sdram_prio_enc: 3 pending bits in, valid plus 2-bit index out.

Verification
REQ-033 ch1 toggles, write, addr 0x00123, data 0xBEEF -> ram_req toggles 1 cycle later with those fields; ram_ack toggles 3 cycles later -> ch1_ack toggles the next edge; ch1_data_read unchanged.
REQ-034 ch0 and ch2 toggle the same cycle, both reads -> ch0 granted first; ch2 granted on the first IDLE cycle after ch0_ack; ram_data_read 0x1234 then 0x5678 lands in ch0_data_read and ch2_data_read respectively.
REQ-035 refresh pulse with ch0 pending in IDLE -> ram_refresh high exactly 1 cycle; ch0 granted exactly REFRESH_HOLD cycles after that pulse.
REQ-036 two refresh pulses during one BUSY -> exactly one ram_refresh pulse after completion.
REQ-037 rst_n low for 1 cycle mid-BUSY -> every output at its reset value next cycle; no chN_ack toggle follows.
